// File: rtl/pipe_register_chain.sv
// pipe_register_chain
//   Elastic chain of DEPTH register stages, each WIDTH bits, with valid/ready
//   handshake on both sides and a synchronous flush. Used to retime and
//   decouple a producer from a consumer. It sustains one transfer per cycle.
//   Under back-pressure it holds data without losing any.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset (clears valid and data)
//   flush      synchronous clear of all stage valid bits (data kept)
//   in_data    upstream data
//   in_valid   upstream data valid
//   in_ready   chain accepts in_data this cycle
//   out_data   data of the last stage
//   out_valid  last stage holds valid data
//   out_ready  downstream accepts out_data this cycle
//   occupancy  count of valid stages (only with PIPE_REG_OCCUPANCY_EN)
//
// Configuration
//   PIPE_REG_OCCUPANCY_EN  when defined, adds the occupancy port and its counter.

module pipe_register_chain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_REG_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] prev_valid;
  logic [WIDTH-1:0] prev_data [DEPTH];

  // A stage can load when it is empty or when the stage after it moves on.
  // The chain is evaluated from the output side toward the input side.
  always_comb begin : ready_chain
    logic downstream;
    downstream  = out_ready;
    stage_ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || downstream;
      downstream     = stage_ready[k];
    end
  end

  // Source of each stage: stage 0 takes the upstream port, others the stage before.
  always_comb begin
    prev_valid[0] = in_valid;
    prev_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_data[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else if (flush) begin
      // Data registers are kept; only the valid bits are dropped.
      valid_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= prev_valid[k];
          // Data loads only when a valid item arrives, so an idle in_data
          // (possibly X) never reaches the registers.
          if (prev_valid[k]) begin
            data_q[k] <= prev_data[k];
          end
        end
      end
    end
  end

  assign in_ready  = stage_ready[0] && !flush;
  assign out_valid = valid_q[DEPTH-1] && !flush;
  assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (xfer_in && !xfer_out) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!xfer_in && xfer_out) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule
